// File: rtl/regfile_writeback_if.sv
// Issue/commit bundle between the issue stage and the register-file write-back unit.
// The master drives issues; the slave (write-back unit) returns the register file and the commit status.
interface regfile_writeback_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int FWD_DEPTH = 2
);
  localparam int AW = $clog2(NREG);

  logic                      uart_valid;
  logic [XLEN-1:0]           uart_data;
  logic                      load_valid;
  logic                      load_finish;
  logic [XLEN-1:0]           load_data;
  logic                      move_valid;
  logic [XLEN-1:0]           move_data;
  logic                      alu_valid;
  logic [XLEN-1:0]           alu_data;
  logic [AW-1:0]             waddr;
  logic [NREG*XLEN-1:0]      regs;
  logic                      done;
  logic [AW-1:0]             done_addr;
  logic                      busy;
  logic                      drop;
  logic [FWD_DEPTH*XLEN-1:0] fwd_data;
  logic [FWD_DEPTH*AW-1:0]   fwd_addr;
  logic [FWD_DEPTH-1:0]      fwd_valid;

  modport master (
    output uart_valid, uart_data, load_valid, load_finish, load_data,
           move_valid, move_data, alu_valid, alu_data, waddr,
    input  regs, done, done_addr, busy, drop, fwd_data, fwd_addr, fwd_valid
  );

  modport slave (
    input  uart_valid, uart_data, load_valid, load_finish, load_data,
           move_valid, move_data, alu_valid, alu_data, waddr,
    output regs, done, done_addr, busy, drop, fwd_data, fwd_addr, fwd_valid
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-back unit: commits UART, load, move and ALU results under one FSM,
// with a completion pulse and a shift-register forwarding history for hazard logic.
module regfile_writeback #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int FWD_DEPTH = 2,
  parameter bit ZERO_REG  = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  regfile_writeback_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, ALU_WR, LOAD_WAIT, MOVE_FIN} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic                done_reg, done_next;
  logic                drop_reg, drop_next;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [XLEN-1:0]     commit_data;
  logic                any_issue;

  logic [XLEN-1:0]      fwd_data_reg [FWD_DEPTH];
  logic [AW-1:0]        fwd_addr_reg [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] fwd_valid_reg;

  assign any_issue = bus.uart_valid | bus.load_valid | bus.move_valid | bus.alu_valid;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    done_next  = 1'b0;
    drop_next  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr_reg;
    wr_data    = bus.alu_data;
    case (state_reg)
      IDLE: begin
        if (bus.uart_valid) begin
          addr_next = bus.waddr;
          wr_en     = 1'b1;
          wr_addr   = bus.waddr;
          wr_data   = bus.uart_data;
          done_next = 1'b1;
          drop_next = bus.load_valid | bus.move_valid | bus.alu_valid;
        end else if (bus.load_valid) begin
          addr_next  = bus.waddr;
          state_next = LOAD_WAIT;
          drop_next  = bus.move_valid | bus.alu_valid;
        end else if (bus.move_valid) begin
          // Move data is only valid in the issue cycle, so it is written immediately.
          addr_next  = bus.waddr;
          wr_en      = 1'b1;
          wr_addr    = bus.waddr;
          wr_data    = bus.move_data;
          state_next = MOVE_FIN;
          drop_next  = bus.alu_valid;
        end else if (bus.alu_valid) begin
          addr_next  = bus.waddr;
          state_next = ALU_WR;
        end
      end
      ALU_WR: begin
        wr_en      = 1'b1;
        wr_data    = bus.alu_data;
        done_next  = 1'b1;
        state_next = IDLE;
        drop_next  = any_issue;
      end
      LOAD_WAIT: begin
        if (bus.load_finish) begin
          wr_en      = 1'b1;
          wr_data    = bus.load_data;
          done_next  = 1'b1;
          state_next = IDLE;
        end
        drop_next = any_issue;
      end
      MOVE_FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
        drop_next  = any_issue;
      end
      default: state_next = IDLE;
    endcase
  end

  // Hardwired-zero register: forwarding must see the value the register really holds.
  assign commit_data = (ZERO_REG && wr_addr == '0) ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      done_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      done_reg  <= done_next;
      drop_reg  <= drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        fwd_data_reg[k] <= '0;
        fwd_addr_reg[k] <= '0;
      end
      fwd_valid_reg <= '0;
    end else if (wr_en) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        fwd_data_reg[k]  <= fwd_data_reg[k-1];
        fwd_addr_reg[k]  <= fwd_addr_reg[k-1];
        fwd_valid_reg[k] <= fwd_valid_reg[k-1];
      end
      fwd_data_reg[0]  <= commit_data;
      fwd_addr_reg[0]  <= wr_addr;
      fwd_valid_reg[0] <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [XLEN-1:0] r_reg;
      if (ZERO_REG && gi == 0) begin : g_zero
        assign r_reg = '0;
      end else begin : g_rw
        always_ff @(posedge clk) begin
          if (!rstn) begin
            r_reg <= '0;
          end else if (wr_en && wr_addr == AW'(gi)) begin
            r_reg <= wr_data;
          end
        end
      end
      assign bus.regs[gi*XLEN +: XLEN] = r_reg;
    end

    for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_fwd
      assign bus.fwd_data[gi*XLEN +: XLEN] = fwd_data_reg[gi];
      assign bus.fwd_addr[gi*AW +: AW]     = fwd_addr_reg[gi];
    end
  endgenerate

  assign bus.fwd_valid = fwd_valid_reg;
  assign bus.done      = done_reg;
  assign bus.done_addr = addr_reg;
  assign bus.drop      = drop_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected commits are queued at issue and
// checked against each done pulse; a second instance covers the writable register 0 case.
module tb_regfile_writeback;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int FWD_DEPTH = 2;
  localparam int AW = $clog2(NREG);

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } commit_t;

  logic clk;
  logic rstn;
  int   n_total;
  int   n_bad;
  int   n_done;
  int   n_push;
  commit_t exp_q[$];

  regfile_writeback_if #(.XLEN(XLEN), .NREG(NREG), .FWD_DEPTH(FWD_DEPTH)) bus_a ();
  regfile_writeback_if #(.XLEN(XLEN), .NREG(NREG), .FWD_DEPTH(FWD_DEPTH)) bus_b ();

  regfile_writeback #(.XLEN(XLEN), .NREG(NREG), .FWD_DEPTH(FWD_DEPTH), .ZERO_REG(1'b1)) dut_a (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_a.slave)
  );

  regfile_writeback #(.XLEN(XLEN), .NREG(NREG), .FWD_DEPTH(FWD_DEPTH), .ZERO_REG(1'b0)) dut_b (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rd_a(input int i);
    return bus_a.regs[i*XLEN +: XLEN];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    commit_t c;
    c.addr = a;
    c.data = d;
    exp_q.push_back(c);
    n_push++;
  endtask

  task automatic clear_inputs();
    bus_a.uart_valid = 1'b0; bus_a.load_valid = 1'b0; bus_a.move_valid = 1'b0;
    bus_a.alu_valid  = 1'b0; bus_a.load_finish = 1'b0;
    bus_b.uart_valid = 1'b0; bus_b.load_valid = 1'b0; bus_b.move_valid = 1'b0;
    bus_b.alu_valid  = 1'b0; bus_b.load_finish = 1'b0;
  endtask

  // Every done pulse must match the oldest outstanding expected commit.
  always @(negedge clk) begin
    if (rstn && bus_a.done === 1'b1) begin
      commit_t c;
      n_done++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'(bus_a.done_addr), 64'hFFFF_FFFF);
      end else begin
        c = exp_q.pop_front();
        $display("commit addr=%0d data=%h", bus_a.done_addr, bus_a.fwd_data[XLEN-1:0]);
        check_eq("done_addr", 64'(bus_a.done_addr), 64'(c.addr));
        check_eq("fwd0_data", 64'(bus_a.fwd_data[XLEN-1:0]), 64'(c.data));
        check_eq("fwd0_addr", 64'(bus_a.fwd_addr[AW-1:0]), 64'(c.addr));
        check_eq("fwd0_valid", 64'(bus_a.fwd_valid[0]), 64'd1);
        check_eq("reg_commit", 64'(rd_a(int'(c.addr))), 64'(c.data));
      end
    end
  end

  initial begin
    n_total = 0; n_bad = 0; n_done = 0; n_push = 0;
    rstn = 1'b0;
    clear_inputs();
    bus_a.uart_data = '0; bus_a.load_data = '0; bus_a.move_data = '0;
    bus_a.alu_data  = '0; bus_a.waddr = '0;
    bus_b.uart_data = '0; bus_b.load_data = '0; bus_b.move_data = '0;
    bus_b.alu_data  = '0; bus_b.waddr = '0;
    tick();
    tick();
    rstn = 1'b1;

    check_eq("rst_regs_zero", 64'(|bus_a.regs), 64'd0);
    check_eq("rst_busy", 64'(bus_a.busy), 64'd0);
    check_eq("rst_done", 64'(bus_a.done), 64'd0);
    check_eq("rst_fwd_valid", 64'(bus_a.fwd_valid), 64'd0);

    // ALU: data arrives the cycle after issue, done two cycles after issue.
    bus_a.alu_valid = 1'b1; bus_a.waddr = 5'd5;
    push(5'd5, 32'hDEADBEEF);
    tick();
    bus_a.alu_valid = 1'b0; bus_a.alu_data = 32'hDEADBEEF;
    check_eq("alu_busy", 64'(bus_a.busy), 64'd1);
    check_eq("alu_done_early", 64'(bus_a.done), 64'd0);
    tick();
    check_eq("alu_done", 64'(bus_a.done), 64'd1);
    check_eq("alu_reg5", 64'(rd_a(5)), 64'hDEADBEEF);
    tick();
    check_eq("alu_done_pulse", 64'(bus_a.done), 64'd0);

    // Same-cycle uart + alu: uart wins, alu is dropped.
    bus_a.uart_valid = 1'b1; bus_a.uart_data = 32'hAA; bus_a.waddr = 5'd3;
    bus_a.alu_valid = 1'b1; bus_a.alu_data = 32'h55;
    push(5'd3, 32'hAA);
    tick();
    clear_inputs();
    bus_a.alu_data = 32'h77;
    check_eq("prio_done", 64'(bus_a.done), 64'd1);
    check_eq("prio_drop", 64'(bus_a.drop), 64'd1);
    check_eq("prio_busy", 64'(bus_a.busy), 64'd0);
    tick();
    check_eq("prio_reg3", 64'(rd_a(3)), 64'hAA);
    check_eq("prio_drop_pulse", 64'(bus_a.drop), 64'd0);
    check_eq("prio_no_alu_done", 64'(bus_a.done), 64'd0);

    // Three back-to-back uart writes; history keeps the two newest.
    for (int i = 1; i <= 3; i++) begin
      bus_a.uart_valid = 1'b1; bus_a.uart_data = 32'(i); bus_a.waddr = AW'(i);
      push(AW'(i), 32'(i));
      tick();
      check_eq("b2b_done", 64'(bus_a.done), 64'd1);
    end
    clear_inputs();
    check_eq("b2b_fwd1_data", 64'(bus_a.fwd_data[XLEN +: XLEN]), 64'd2);
    check_eq("b2b_fwd1_addr", 64'(bus_a.fwd_addr[AW +: AW]), 64'd2);
    check_eq("b2b_fwd_valid", 64'(bus_a.fwd_valid), 64'd3);
    tick();

    // Register 0: hardwired on dut_a, writable on dut_b.
    bus_a.uart_valid = 1'b1; bus_a.uart_data = 32'hFFFF; bus_a.waddr = '0;
    bus_b.uart_valid = 1'b1; bus_b.uart_data = 32'hFFFF; bus_b.waddr = '0;
    push('0, 32'h0);
    tick();
    clear_inputs();
    check_eq("zero_done", 64'(bus_a.done), 64'd1);
    check_eq("zero_reg0", 64'(rd_a(0)), 64'd0);
    check_eq("nozero_done", 64'(bus_b.done), 64'd1);
    check_eq("nozero_reg0", 64'(bus_b.regs[XLEN-1:0]), 64'hFFFF);
    check_eq("nozero_fwd0", 64'(bus_b.fwd_data[XLEN-1:0]), 64'hFFFF);
    tick();

    // Move: written at issue, done one cycle later.
    bus_a.move_valid = 1'b1; bus_a.move_data = 32'h5A5A; bus_a.waddr = 5'd10;
    push(5'd10, 32'h5A5A);
    tick();
    clear_inputs();
    check_eq("move_busy", 64'(bus_a.busy), 64'd1);
    check_eq("move_done_early", 64'(bus_a.done), 64'd0);
    check_eq("move_reg10", 64'(rd_a(10)), 64'h5A5A);
    check_eq("move_fwd0", 64'(bus_a.fwd_data[XLEN-1:0]), 64'h5A5A);
    tick();
    check_eq("move_done", 64'(bus_a.done), 64'd1);
    check_eq("move_idle", 64'(bus_a.busy), 64'd0);
    tick();

    // Load with a stale load_finish at issue, and an alu issue dropped while waiting.
    bus_a.load_valid = 1'b1; bus_a.waddr = 5'd7;
    bus_a.load_finish = 1'b1; bus_a.load_data = 32'h9999;
    push(5'd7, 32'h1234);
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check_eq("load_busy", 64'(bus_a.busy), 64'd1);
      check_eq("load_wait_done", 64'(bus_a.done), 64'd0);
      bus_a.alu_valid = (i == 1);
      bus_a.waddr = 5'd9; bus_a.alu_data = 32'hBAD;
      tick();
      if (i == 1) check_eq("load_drop", 64'(bus_a.drop), 64'd1);
    end
    clear_inputs();
    bus_a.load_finish = 1'b1; bus_a.load_data = 32'h1234;
    tick();
    clear_inputs();
    check_eq("load_done", 64'(bus_a.done), 64'd1);
    check_eq("load_reg7", 64'(rd_a(7)), 64'h1234);
    check_eq("load_reg9_untouched", 64'(rd_a(9)), 64'd0);
    check_eq("load_idle", 64'(bus_a.busy), 64'd0);
    tick();

    // Reset mid-LOAD_WAIT abandons the load with no commit.
    bus_a.load_valid = 1'b1; bus_a.waddr = 5'd12;
    tick();
    clear_inputs();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus_a.load_finish = 1'b1; bus_a.load_data = 32'hABC;
    tick();
    clear_inputs();
    tick();
    check_eq("rst2_regs_zero", 64'(|bus_a.regs), 64'd0);
    check_eq("rst2_busy", 64'(bus_a.busy), 64'd0);
    check_eq("rst2_fwd_valid", 64'(bus_a.fwd_valid), 64'd0);
    check_eq("rst2_reg12", 64'(rd_a(12)), 64'd0);
    tick();

    check_eq("done_count", 64'(n_done), 64'(n_push));
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
